// File: rtl/enum_job_sequencer.sv
// Two-requester round-robin job sequencer with an IDLE/RUNNING/DONE controller.
// Runs the granted job for max(len, 1) enabled cycles and then pulses done for one cycle.
module enum_job_sequencer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       req,
    input  logic [CNT_W-1:0] len0,
    input  logic [CNT_W-1:0] len1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic [1:0]       state_o,
    output logic             done,
    output logic             done_id
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRunning = 2'd1,
        StDone    = 2'd2
    } state_e;

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_owner;
    logic             r_last_id;
    logic [1:0]       r_gnt;
    logic             r_busy;
    logic             r_done;
    logic             r_done_id;

    logic             w_winner;
    logic [CNT_W-1:0] w_len;
    logic [CNT_W-1:0] w_load;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        if (req == 2'b11) begin
            w_winner = ~r_last_id;
        end else begin
            w_winner = req[1];
        end
        w_len = w_winner ? len1 : len0;
    end

    // A zero length runs exactly like a length of one.
    assign w_load = (w_len == '0) ? '0 : (w_len - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_owner   <= 1'b0;
            r_last_id <= 1'b1;
            r_gnt     <= 2'b00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
        end else begin
            r_gnt  <= 2'b00;
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (en && (req != 2'b00)) begin
                        r_state   <= StRunning;
                        r_owner   <= w_winner;
                        r_last_id <= w_winner;
                        r_cnt     <= w_load;
                        r_gnt     <= w_winner ? 2'b10 : 2'b01;
                        r_busy    <= 1'b1;
                    end
                end
                StRunning: begin
                    // With en low the counter and state hold; there is no abort.
                    if (en) begin
                        if (r_cnt == '0) begin
                            r_state   <= StDone;
                            r_done    <= 1'b1;
                            r_done_id <= r_owner;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign busy    = r_busy;
    assign state_o = r_state;
    assign done    = r_done;
    assign done_id = r_done_id;

endmodule

// File: tb/tb_enum_job_sequencer.sv
// Self-checking bench for enum_job_sequencer: directed jobs feed a scoreboard of
// expected completions (owner and RUNNING length) that a negedge monitor consumes.
module tb_enum_job_sequencer;

    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [1:0]       req;
    logic [CNT_W-1:0] len0;
    logic [CNT_W-1:0] len1;
    logic [1:0]       gnt;
    logic             busy;
    logic [1:0]       state_o;
    logic             done;
    logic             done_id;

    enum_job_sequencer #(
        .CNT_W(CNT_W)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .req    (req),
        .len0   (len0),
        .len1   (len1),
        .gnt    (gnt),
        .busy   (busy),
        .state_o(state_o),
        .done   (done),
        .done_id(done_id)
    );

    typedef struct {
        logic id;
        int   runlen;
    } job_t;

    job_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_gnt   = 0;
    int run_cnt = 0;
    logic gnt_id = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test, required finish before 300000");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_job(input logic id, input int runlen);
        job_t j;
        j.id     = id;
        j.runlen = runlen;
        sb_q.push_back(j);
    endtask

    task automatic monitor_step();
        job_t e;
        if (!rst_n) begin
            run_cnt = 0;
        end else begin
            if (gnt != 2'b00) begin
                n_gnt = n_gnt + 1;
                check_eq("gnt_onehot", $countones(gnt), 1);
                check_eq("gnt_state", state_o, 1);
                check_eq("gnt_busy", busy, 1);
                gnt_id  = gnt[1];
                run_cnt = 0;
            end
            if (state_o == 2'd1) run_cnt = run_cnt + 1;
            if (done) begin
                if (sb_q.size() == 0) begin
                    check_eq("done_unexpected", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("done_id", done_id, e.id);
                    check_eq("job_gnt_id", gnt_id, e.id);
                    check_eq("run_len", run_cnt, e.runlen);
                    check_eq("done_state", state_o, 2);
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            monitor_step();
        end
    end

    task automatic wait_gnt(input int max_cyc, output logic id, output int c);
        bit got;
        got = 1'b0;
        id  = 1'b0;
        c   = 0;
        for (int i = 0; i < max_cyc && !got; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin
                got = 1'b1;
                id  = gnt[1];
                c   = cyc;
            end
        end
        if (!got) check_eq("gnt_timeout", 0, 1);
    endtask

    task automatic wait_done(input int max_cyc, output int c);
        bit got;
        got = 1'b0;
        c   = 0;
        for (int i = 0; i < max_cyc && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                c   = cyc;
            end
        end
        if (!got) check_eq("done_timeout", 0, 1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic id;
        int   g;
        int   g0;
        int   dc;
        int   c0;
        int   prev;
        int   ng;

        rst_n = 1'b0;
        en    = 1'b0;
        req   = 2'b00;
        len0  = '0;
        len1  = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_state", state_o, 0);
        check_eq("rst_gnt", gnt, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_done_id", done_id, 0);
        rst_n = 1'b1;
        en    = 1'b1;
        @(negedge clk);

        // Single job, length 3
        len0 = 8'd3;
        push_job(1'b0, 3);
        c0  = cyc;
        req = 2'b01;
        wait_gnt(10, id, g);
        check_eq("single_gnt_id", id, 0);
        check_eq("single_gnt_lat", g - c0, 1);
        req = 2'b00;
        wait_done(20, dc);
        check_eq("single_done_lat", dc - g, 3);
        @(negedge clk);
        check_eq("single_idle_state", state_o, 0);
        check_eq("single_idle_busy", busy, 0);
        check_eq("single_idle_done", done, 0);

        // Tie after reset alternates 0,1,0,1; grants L+2 cycles apart
        apply_reset();
        len0 = 8'd2;
        len1 = 8'd2;
        for (int i = 0; i < 4; i++) push_job(1'(i % 2), 2);
        req  = 2'b11;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(20, id, g);
            check_eq("alt_gnt_id", id, 32'(i % 2));
            if (i > 0) check_eq("alt_spacing", g - prev, 2 + 2);
            prev = g;
        end
        req = 2'b00;
        wait_done(20, dc);
        @(negedge clk);

        // Zero length runs one cycle
        len1 = 8'd0;
        push_job(1'b1, 1);
        req = 2'b10;
        wait_gnt(10, id, g);
        check_eq("zero_gnt_id", id, 1);
        req = 2'b00;
        wait_done(10, dc);
        check_eq("zero_done_lat", dc - g, 1);
        @(negedge clk);

        // Two paused cycles stretch a length-4 job to 6 RUNNING cycles
        len0 = 8'd4;
        push_job(1'b0, 6);
        req = 2'b01;
        wait_gnt(10, id, g);
        req = 2'b00;
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("pause_state", state_o, 1);
        en = 1'b1;
        wait_done(20, dc);
        check_eq("pause_done_lat", dc - g, 6);
        @(negedge clk);

        // en low in IDLE blocks grants
        en  = 1'b0;
        req = 2'b01;
        ng  = n_gnt;
        repeat (6) @(negedge clk);
        check_eq("en_off_no_gnt", n_gnt - ng, 0);
        check_eq("en_off_state", state_o, 0);
        req = 2'b00;
        en  = 1'b1;
        @(negedge clk);

        // Asynchronous reset mid-run: no done for the aborted job
        len0 = 8'd5;
        req  = 2'b01;
        wait_gnt(10, id, g);
        req = 2'b00;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_state", state_o, 0);
        check_eq("async_rst_busy", busy, 0);
        check_eq("async_rst_gnt", gnt, 0);
        check_eq("async_rst_done", done, 0);
        repeat (3) @(negedge clk);
        check_eq("rst_hold_state", state_o, 0);
        rst_n = 1'b1;

        // Tie after reset grants 0; req0 dropped after grant, waiting req1 follows
        len0 = 8'd1;
        len1 = 8'd1;
        push_job(1'b0, 1);
        push_job(1'b1, 1);
        req = 2'b11;
        wait_gnt(10, id, g0);
        check_eq("post_rst_tie_id", id, 0);
        @(negedge clk);
        req = 2'b10;
        wait_gnt(10, id, g);
        check_eq("drop_next_id", id, 1);
        check_eq("drop_spacing", g - g0, 1 + 2);
        req = 2'b00;
        wait_done(10, dc);
        repeat (3) @(negedge clk);
        check_eq("sb_empty", sb_q.size(), 0);
        check_eq("final_state", state_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
